// File: rtl/tap_ram_arb.sv
// Arbiter between the host config port and the FIR engine for one shared tap RAM.
// Engine has priority; a host request that keeps losing is promoted after MAX_WAIT cycles.
module tap_ram_arb #(
    parameter int ADDR_WIDTH = 12,
    parameter int DEPTH      = 12,
    parameter int BIT_WIDTH  = 32,
    parameter int MAX_WAIT   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  h_req,
    input  logic                  h_we,
    input  logic [ADDR_WIDTH-1:0] h_addr,
    input  logic [BIT_WIDTH-1:0]  h_wdata,
    output logic                  h_gnt,
    output logic                  h_rvalid,
    output logic [BIT_WIDTH-1:0]  h_rdata,
    input  logic                  e_req,
    input  logic [ADDR_WIDTH-1:0] e_addr,
    output logic                  e_gnt,
    output logic                  e_rvalid,
    output logic [BIT_WIDTH-1:0]  e_rdata,
    output logic [3:0]            ram_we,
    output logic [3:0]            ram_re,
    output logic [ADDR_WIDTH-1:0] ram_waddr,
    output logic [ADDR_WIDTH-1:0] ram_raddr,
    output logic [BIT_WIDTH-1:0]  ram_wdi,
    input  logic [BIT_WIDTH-1:0]  ram_rdo
);

    // state      | meaning
    // NORMAL     | engine wins when both request
    // HOST_FORCE | host has waited MAX_WAIT cycles and wins unconditionally
    typedef enum logic {NORMAL, HOST_FORCE} state_t;

    localparam int WCW = (MAX_WAIT < 1) ? 1 : $clog2(MAX_WAIT + 1);
    localparam logic [WCW-1:0]        MAX_W   = WCW'(MAX_WAIT);
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);

    state_t                state;
    logic [WCW-1:0]        wcnt;
    logic [WCW-1:0]        wcnt_nxt;
    logic                  rsp_vld;
    logic                  rsp_tag;
    logic                  rsp_hit;
    logic                  rd_gnt;
    logic                  acc_hit;
    logic                  h_hit;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [BIT_WIDTH-1:0]  rsp_data;

    always_comb begin
        h_gnt = 1'b0;
        e_gnt = 1'b0;
        if (!rst) begin
            if (state == HOST_FORCE && h_req) begin
                h_gnt = 1'b1;
            end else if (e_req) begin
                e_gnt = 1'b1;
            end else if (h_req) begin
                h_gnt = 1'b1;
            end
        end
    end

    always_comb begin
        wcnt_nxt = wcnt;
        if (!h_req || h_gnt) begin
            wcnt_nxt = '0;
        end else if (e_gnt && wcnt != MAX_W) begin
            wcnt_nxt = wcnt + 1'b1;
        end
    end

    assign acc_addr  = e_gnt ? e_addr : h_addr;
    assign acc_hit   = {1'b0, acc_addr} < DEPTH_L;
    assign h_hit     = {1'b0, h_addr} < DEPTH_L;
    assign rd_gnt    = e_gnt || (h_gnt && !h_we);

    // Out-of-range accesses are granted but never reach the RAM.
    assign ram_re    = (rd_gnt && acc_hit) ? 4'hF : 4'h0;
    assign ram_we    = (h_gnt && h_we && h_hit) ? 4'hF : 4'h0;
    assign ram_raddr = acc_addr;
    assign ram_waddr = h_addr;
    assign ram_wdi   = h_wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= NORMAL;
            wcnt    <= '0;
            rsp_vld <= 1'b0;
            rsp_tag <= 1'b0;
            rsp_hit <= 1'b0;
        end else begin
            wcnt    <= wcnt_nxt;
            rsp_vld <= rd_gnt;
            rsp_tag <= h_gnt;
            rsp_hit <= acc_hit;
            case (state)
                NORMAL:     if (wcnt_nxt == MAX_W) state <= HOST_FORCE;
                HOST_FORCE: if (h_gnt || !h_req) state <= NORMAL;
                default:    state <= NORMAL;
            endcase
        end
    end

    assign rsp_data = rsp_hit ? ram_rdo : '0;
    assign h_rvalid = rsp_vld && rsp_tag;
    assign e_rvalid = rsp_vld && !rsp_tag;
    assign h_rdata  = h_rvalid ? rsp_data : '0;
    assign e_rdata  = e_rvalid ? rsp_data : '0;

endmodule

// File: tb/tb_tap_ram_arb.sv
// Directed bench for tap_ram_arb with a small registered-read RAM attached.
module tb_tap_ram_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        h_req, h_we, e_req;
    logic [11:0] h_addr, e_addr;
    logic [31:0] h_wdata;
    logic        h_gnt, h_rvalid, e_gnt, e_rvalid;
    logic [31:0] h_rdata, e_rdata;
    logic [3:0]  ram_we, ram_re;
    logic [11:0] ram_waddr, ram_raddr;
    logic [31:0] ram_wdi;
    logic [31:0] ram_rdo = 32'h0;

    logic [31:0] wr_mem [16];
    logic        wr_vld [16] = '{default: 1'b0};

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tap_ram_arb dut (
        .clk(clk), .rst(rst),
        .h_req(h_req), .h_we(h_we), .h_addr(h_addr), .h_wdata(h_wdata),
        .h_gnt(h_gnt), .h_rvalid(h_rvalid), .h_rdata(h_rdata),
        .e_req(e_req), .e_addr(e_addr), .e_gnt(e_gnt),
        .e_rvalid(e_rvalid), .e_rdata(e_rdata),
        .ram_we(ram_we), .ram_re(ram_re), .ram_waddr(ram_waddr),
        .ram_raddr(ram_raddr), .ram_wdi(ram_wdi), .ram_rdo(ram_rdo)
    );

    // Unwritten words read back as 0x1000_0aaa (a = address nibble).
    function automatic logic [31:0] init_val(input logic [3:0] a);
        return 32'h1000_0000 | {20'h0, a, a, a};
    endfunction

    always @(posedge clk) begin
        if (ram_we == 4'hF) begin
            wr_mem[ram_waddr[3:0]] <= ram_wdi;
            wr_vld[ram_waddr[3:0]] <= 1'b1;
        end
        if (ram_re == 4'hF)
            ram_rdo <= wr_vld[ram_raddr[3:0]] ? wr_mem[ram_raddr[3:0]] : init_val(ram_raddr[3:0]);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; h_req = 1'b1; h_we = 1'b0; h_addr = 12'd0; h_wdata = 32'h0;
        e_req = 1'b1; e_addr = 12'd0;
        #7;
        chk("rst_h_gnt", {31'h0, h_gnt}, 32'd0);
        chk("rst_e_gnt", {31'h0, e_gnt}, 32'd0);
        chk("rst_ram_re", {28'h0, ram_re}, 32'd0);
        chk("rst_ram_we", {28'h0, ram_we}, 32'd0);
        chk("rst_rvalid", {30'h0, h_rvalid, e_rvalid}, 32'd0);
        chk("rst_rdata", h_rdata | e_rdata, 32'd0);

        tick(); rst = 1'b0; h_req = 1'b0; e_req = 1'b0; #4;
        chk("idle_gnt", {30'h0, h_gnt, e_gnt}, 32'd0);

        // host write then engine read of the same word
        tick(); h_req = 1'b1; h_we = 1'b1; h_addr = 12'd3; h_wdata = 32'hDEADBEEF; #4;
        chk("wr_h_gnt", {31'h0, h_gnt}, 32'd1);
        chk("wr_e_gnt", {31'h0, e_gnt}, 32'd0);
        chk("wr_ram_we", {28'h0, ram_we}, 32'hF);
        chk("wr_ram_waddr", {20'h0, ram_waddr}, 32'd3);
        chk("wr_ram_wdi", ram_wdi, 32'hDEADBEEF);
        tick(); h_req = 1'b0; h_we = 1'b0; e_req = 1'b1; e_addr = 12'd3; #4;
        chk("rd3_e_gnt", {31'h0, e_gnt}, 32'd1);
        chk("rd3_ram_re", {28'h0, ram_re}, 32'hF);
        chk("rd3_ram_raddr", {20'h0, ram_raddr}, 32'd3);
        chk("wr_no_rsp", {31'h0, h_rvalid}, 32'd0);
        tick(); e_req = 1'b0; #4;
        chk("rd3_e_rvalid", {31'h0, e_rvalid}, 32'd1);
        chk("rd3_e_rdata", e_rdata, 32'hDEADBEEF);
        chk("rd3_h_rvalid", {31'h0, h_rvalid}, 32'd0);

        // engine streams addresses 0..11 back to back
        for (int i = 0; i < 13; i++) begin
            tick(); e_req = (i < 12); e_addr = (i < 12) ? 12'(i) : 12'd0; #4;
            if (i < 12) chk("burst_e_gnt", {31'h0, e_gnt}, 32'd1);
            if (i > 0) begin
                chk("burst_e_rvalid", {31'h0, e_rvalid}, 32'd1);
                chk("burst_e_rdata", e_rdata,
                    (i == 4) ? 32'hDEADBEEF : (32'h1000_0000 + 32'(i - 1) * 32'h111));
            end
        end

        // simultaneous reads: engine first
        tick(); h_req = 1'b1; h_we = 1'b0; h_addr = 12'd7; e_req = 1'b1; e_addr = 12'd2; #4;
        chk("both_e_gnt", {31'h0, e_gnt}, 32'd1);
        chk("both_h_gnt", {31'h0, h_gnt}, 32'd0);
        chk("both_e_rdata_idle", e_rdata, 32'd0);
        tick(); e_req = 1'b0; #4;
        chk("both_h_gnt2", {31'h0, h_gnt}, 32'd1);
        chk("both_e_gnt2", {31'h0, e_gnt}, 32'd0);
        chk("both_e_rdata", e_rdata, 32'h1000_0222);
        tick(); h_req = 1'b0; #4;
        chk("both_h_rvalid", {31'h0, h_rvalid}, 32'd1);
        chk("both_h_rdata", h_rdata, 32'h1000_0777);
        chk("both_e_rvalid", {31'h0, e_rvalid}, 32'd0);

        // starvation limit: host wins on its fifth waiting cycle
        for (int c = 0; c < 7; c++) begin
            tick(); e_req = (c < 6); h_req = (c < 5); e_addr = 12'd1; h_addr = 12'd5; h_we = 1'b0; #4;
            chk("starve_no_dual", {31'h0, h_gnt & e_gnt}, 32'd0);
            if (c < 4) begin
                chk("starve_e_gnt", {31'h0, e_gnt}, 32'd1);
                chk("starve_h_gnt", {31'h0, h_gnt}, 32'd0);
            end else if (c == 4) begin
                chk("force_h_gnt", {31'h0, h_gnt}, 32'd1);
                chk("force_e_gnt", {31'h0, e_gnt}, 32'd0);
            end else if (c == 5) begin
                chk("after_e_gnt", {31'h0, e_gnt}, 32'd1);
                chk("after_h_rvalid", {31'h0, h_rvalid}, 32'd1);
                chk("after_h_rdata", h_rdata, 32'h1000_0555);
                chk("after_e_rvalid", {31'h0, e_rvalid}, 32'd0);
            end else begin
                chk("after_e_rdata", e_rdata, 32'h1000_0111);
            end
        end

        // out-of-range host accesses
        tick(); h_req = 1'b1; h_we = 1'b0; h_addr = 12'd12; e_req = 1'b0; #4;
        chk("oor_rd_gnt", {31'h0, h_gnt}, 32'd1);
        chk("oor_rd_ram_re", {28'h0, ram_re}, 32'd0);
        tick(); h_we = 1'b1; h_addr = 12'd15; h_wdata = 32'h1234_5678; #4;
        chk("oor_wr_gnt", {31'h0, h_gnt}, 32'd1);
        chk("oor_wr_ram_we", {28'h0, ram_we}, 32'd0);
        chk("oor_rd_rvalid", {31'h0, h_rvalid}, 32'd1);
        chk("oor_rd_rdata", h_rdata, 32'd0);
        tick(); h_req = 1'b0; h_we = 1'b0; #4;
        chk("oor_wr_no_rsp", {31'h0, h_rvalid}, 32'd0);
        chk("oor_rdata_idle", h_rdata, 32'd0);

        // reset right after an engine grant kills its response
        tick(); e_req = 1'b1; e_addr = 12'd4; #4;
        chk("kill_e_gnt", {31'h0, e_gnt}, 32'd1);
        tick(); rst = 1'b1; e_addr = 12'd6; #4;
        chk("kill_e_rvalid", {31'h0, e_rvalid}, 32'd0);
        chk("kill_e_gnt_rst", {31'h0, e_gnt}, 32'd0);
        chk("kill_ram_re", {28'h0, ram_re}, 32'd0);
        tick(); rst = 1'b0; h_req = 1'b1; h_we = 1'b0; h_addr = 12'd9; #4;
        chk("post_e_gnt", {31'h0, e_gnt}, 32'd1);
        chk("post_h_gnt", {31'h0, h_gnt}, 32'd0);
        chk("post_e_rvalid", {31'h0, e_rvalid}, 32'd0);
        tick(); e_req = 1'b0; #4;
        chk("post_e_rdata", e_rdata, 32'h1000_0666);
        chk("post_h_gnt2", {31'h0, h_gnt}, 32'd1);
        tick(); h_req = 1'b0; #4;
        chk("post_h_rvalid", {31'h0, h_rvalid}, 32'd1);
        chk("post_h_rdata", h_rdata, 32'h1000_0999);

        tick();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/tap_ram_arb.md
TAP_RAM_ARB -- requirements
Module: tap_ram_arb

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 12, width of all address ports.
REQ-002 SHALL have parameter DEPTH, default 12, number of valid RAM words (addresses 0..DEPTH-1).
REQ-003 SHALL have parameter BIT_WIDTH, default 32, data word width.
REQ-004 SHALL have parameter MAX_WAIT, default 4, maximum consecutive cycles a pending host request loses to the engine.
REQ-005 SHALL have the following ports (name  direction  width  meaning), one clock, asynchronous active-high reset:
- clk  in  1  sole clock; all state changes on rising edge
- rst  in  1  asynchronous reset, active high
- h_req  in  1  host (AXI-Lite config side) access request
- h_we  in  1  host access type: 1 write, 0 read
- h_addr  in  ADDR_WIDTH  host word address
- h_wdata  in  BIT_WIDTH  host write data
- h_gnt  out  1  host request accepted this cycle
- h_rvalid  out  1  host read data valid
- h_rdata  out  BIT_WIDTH  host read data
- e_req  in  1  FIR engine read request
- e_addr  in  ADDR_WIDTH  engine word address
- e_gnt  out  1  engine request accepted this cycle
- e_rvalid  out  1  engine read data valid
- e_rdata  out  BIT_WIDTH  engine read data
- ram_we  out  4  RAM write enable
- ram_re  out  4  RAM read enable
- ram_waddr  out  ADDR_WIDTH  RAM write address
- ram_raddr  out  ADDR_WIDTH  RAM read address
- ram_wdi  out  BIT_WIDTH  RAM write data
- ram_rdo  in  BIT_WIDTH  RAM read data, registered, valid one cycle after ram_re

Function
REQ-006 SHALL grant at most one requester per cycle; h_gnt and e_gnt combinational from requests and registered state; never both 1.
REQ-007 SHALL implement a 2-state FSM: NORMAL (engine priority) and HOST_FORCE (host priority).
REQ-008 In NORMAL: e_req=1 -> e_gnt=1; else h_req=1 -> h_gnt=1.
REQ-009 SHALL keep wait counter wcnt (0..MAX_WAIT): increments each cycle h_req=1 and e_gnt=1; clears on h_gnt or h_req=0.
REQ-010 Transition NORMAL->HOST_FORCE when wcnt reaches MAX_WAIT; in HOST_FORCE h_req=1 -> h_gnt=1 regardless of e_req; return to NORMAL on cycle after h_gnt, or if h_req drops.
REQ-011 Requesters SHALL hold req/addr/we/wdata stable until granted; arbiter need not tolerate changes while pending.
REQ-012 Granted read, addr<DEPTH: ram_re=4'hF, ram_raddr=addr that cycle; otherwise ram_re=4'h0.
REQ-013 Granted host write, addr<DEPTH: ram_we=4'hF, ram_waddr=h_addr, ram_wdi=h_wdata that cycle; write complete in that cycle, no response pulse.
REQ-014 Granted read SHALL produce owner's rvalid=1 exactly one cycle after grant, with rdata=ram_rdo; other owner's rvalid=0.
REQ-015 Granted access with addr>=DEPTH SHALL not touch RAM; read returns rvalid next cycle with rdata=0; write silently dropped.
REQ-016 Back-to-back grants SHALL be sustainable every cycle (throughput 1/cycle); response owner tracked by a registered 1-bit tag plus valid bit.
REQ-017 h_rdata/e_rdata SHALL be 0 whenever corresponding rvalid=0.
REQ-018 Host read and write SHALL share one arbitration path; a host write then engine read of same address in next cycle SHALL return new data.

Reset
REQ-019 rst=1 SHALL asynchronously force FSM=NORMAL, wcnt=0, response valid/tag=0; h_rvalid=e_rvalid=0, rdata=0.
REQ-020 During rst=1 h_gnt, e_gnt, ram_we, ram_re SHALL be 0; RAM contents are not cleared.
REQ-021 Reset asserted the cycle after a read grant SHALL suppress that read's rvalid.

Verification
REQ-022 Host write addr 3 data 0xDEADBEEF, then engine read addr 3 -> ram_we=4'hF cycle 0; e_rvalid=1, e_rdata=0xDEADBEEF one cycle after e_gnt.
REQ-023 e_req held high continuously, h_req read addr 5 raised at cycle 0 -> e_gnt cycles 0..3, h_gnt cycle 4, e_gnt cycle 5, h_rvalid cycle 5.
REQ-024 Engine reads addr 0..11 on consecutive cycles -> e_gnt every cycle, e_rvalid every cycle from cycle 1, data in address order.
REQ-025 Host read addr 12 and write addr 15 -> ram_re=ram_we=0; read returns h_rvalid=1 with h_rdata=0; RAM unchanged.
REQ-026 Simultaneous h_req and e_req both reads, wcnt=0 -> e_gnt=1, h_gnt=0; no cycle with both gnt high.
REQ-027 rst pulsed cycle after engine read grant -> e_rvalid stays 0, FSM NORMAL, next request granted normally.
